fsm_ctx_arbiter: RTL and testbench

//  Time-multiplexes one Moore "101" sequence detector (4 states, 2-bit state) across N_CH serial requesters.

---
 rtl/fsm_ctx_arbiter.sv | 95 +++++++++
 tb/tb_fsm_ctx_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm_ctx_arbiter.sv
// Round-robin time-multiplexed "101" Moore detector with per-channel saved state context.
// One bit consumed per cycle; result 1 cycle later. A source holds req/bit_in until its grant edge.
module fsm_ctx_arbiter #(
   parameter  int N_CH = 4,
   localparam int CH_W = $clog2(N_CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] req,
   input  logic [N_CH-1:0] bit_in,
   input  logic [N_CH-1:0] ctx_clr,
   output logic [N_CH-1:0] gnt,
   output logic            out_vld,
   output logic [CH_W-1:0] out_ch,
   output logic            out_det,
   output logic [N_CH-1:0] det
);

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_t;

   state_t          ctx     [N_CH];
   state_t          ctx_nxt [N_CH];
   logic [CH_W-1:0] ptr;
   logic [CH_W-1:0] sel;
   logic            sel_vld;

   function automatic state_t next_state(input state_t s, input logic b);
      state_t n;
      case (s)
         S0:      n = b ? S1 : S0;
         S1:      n = b ? S1 : S2;
         S2:      n = b ? S3 : S0;
         default: n = b ? S1 : S2;
      endcase
      return n;
   endfunction

   // Scan offsets from farthest to nearest so the request closest to ptr wins.
   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N_CH]) begin
            sel     = CH_W'((int'(ptr) + i) % N_CH);
            sel_vld = 1'b1;
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (sel_vld && rst)
         gnt[sel] = 1'b1;
   end

   // A clear overrides the granted bit; the handshake still completes.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         ctx_nxt[i] = ctx[i];
         if (ctx_clr[i])
            ctx_nxt[i] = S0;
         else if (sel_vld && sel == CH_W'(i))
            ctx_nxt[i] = next_state(ctx[i], bit_in[i]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_CH; i++)
            ctx[i] <= S0;
         ptr     <= '0;
         out_vld <= 1'b0;
         out_ch  <= '0;
         out_det <= 1'b0;
         det     <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            ctx[i] <= ctx_nxt[i];
            det[i] <= (ctx_nxt[i] == S3);
         end
         out_vld <= sel_vld;
         if (sel_vld) begin
            out_ch  <= sel;
            out_det <= (ctx_nxt[sel] == S3);
            ptr     <= (sel == CH_W'(N_CH - 1)) ? '0 : sel + CH_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fsm_ctx_arbiter.sv
// Bench for fsm_ctx_arbiter: bit-history model per channel ("101" is the last three bits seen since clear).
module tb_fsm_ctx_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] bit_in = '0;
   logic [3:0] ctx_clr = '0;
   logic [3:0] gnt;
   logic       out_vld;
   logic [1:0] out_ch;
   logic       out_det;
   logic [3:0] det;

   int nchk = 0;
   int nerr = 0;

   int   hist [4];
   int   mptr;
   logic m_vld;
   int   m_ch;
   logic m_det;

   logic [3:0] g;
   int t1_bits [6] = '{1, 0, 1, 1, 0, 1};
   int t1_det  [6] = '{0, 0, 1, 0, 0, 1};
   logic [3:0] t3_bits [6] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
   int t3_ch   [6] = '{1, 2, 1, 2, 1, 2};
   int t3_det  [6] = '{0, 0, 0, 0, 1, 0};

   always #5 clk = ~clk;

   fsm_ctx_arbiter #(.N_CH(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .bit_in  (bit_in),
      .ctx_clr (ctx_clr),
      .gnt     (gnt),
      .out_vld (out_vld),
      .out_ch  (out_ch),
      .out_det (out_det),
      .det     (det)
   );

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int mpick(input logic [3:0] r, input int p);
      for (int i = 0; i < 4; i++)
         if (r[(p + i) % 4]) return (p + i) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] mgnt(input logic [3:0] r, input int p);
      logic [3:0] v;
      int k;
      v = '0;
      k = mpick(r, p);
      if (k >= 0) v[k] = 1'b1;
      return v;
   endfunction

   function automatic logic [3:0] mdetv();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = (hist[i] == 5);
      return v;
   endfunction

   // Model: each channel remembers its last three consumed bits since its last clear.
   initial begin
      for (int i = 0; i < 4; i++) hist[i] = 0;
      mptr = 0; m_vld = 1'b0; m_ch = 0; m_det = 1'b0;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            for (int i = 0; i < 4; i++) hist[i] = 0;
            mptr = 0; m_vld = 1'b0; m_ch = 0; m_det = 1'b0;
         end else begin
            int k;
            k = mpick(req, mptr);
            for (int i = 0; i < 4; i++) begin
               if (ctx_clr[i]) hist[i] = 0;
               else if (i == k) hist[i] = ((hist[i] << 1) | int'(bit_in[i])) & 7;
            end
            m_vld = (k >= 0);
            if (k >= 0) begin
               m_ch  = k;
               m_det = (hist[k] == 5);
               mptr  = (k + 1) % 4;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("cmp_gnt", int'(gnt), int'(mgnt(req, mptr) & {4{rst}}));
         chk("cmp_out_vld", int'(out_vld), int'(m_vld));
         chk("cmp_out_ch", int'(out_ch), m_ch);
         chk("cmp_out_det", int'(out_det), int'(m_det));
         chk("cmp_det", int'(det), int'(mdetv()));
      end
   end

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic cyc(input logic [3:0] r, input logic [3:0] b, input logic [3:0] c,
                      output logic [3:0] gg);
      req = r; bit_in = b; ctx_clr = c;
      #1 gg = gnt;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b0; req = '0; bit_in = '0; ctx_clr = '0;
      @(negedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      #3;
      chk("rst_out_vld", int'(out_vld), 0);
      chk("rst_det", int'(det), 0);
      chk("rst_out_ch", int'(out_ch), 0);
      chk("rst_out_det", int'(out_det), 0);
      req = 4'b1111;
      #1 chk("rst_gnt", int'(gnt), 0);
      req = '0;
      @(negedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 6; i++) begin
         cyc(4'b0001, 4'(t1_bits[i]), 4'b0000, g);
         chk("t1_gnt", int'(g), 1);
         chk("t1_vld", int'(out_vld), 1);
         chk("t1_ch", int'(out_ch), 0);
         chk("t1_det", int'(out_det), t1_det[i]);
      end

      reset_dut();
      for (int i = 0; i < 8; i++) begin
         cyc(4'b1111, 4'b0000, 4'b0000, g);
         chk("t2_gnt", int'(g), 1 << (i % 4));
         chk("t2_ch", int'(out_ch), i % 4);
      end

      for (int i = 0; i < 6; i++) begin
         cyc(4'b0110, t3_bits[i], 4'b0000, g);
         chk("t3_ch", int'(out_ch), t3_ch[i]);
         chk("t3_det", int'(out_det), t3_det[i]);
         chk("t3_det2", int'(det[2]), 0);
      end
      chk("t3_det1", int'(det[1]), 1);

      cyc(4'b1000, 4'b1000, 4'b0000, g);
      chk("t4_gnt_a", int'(g), 8);
      cyc(4'b1000, 4'b0000, 4'b0000, g);
      cyc(4'b1000, 4'b1000, 4'b1000, g);
      chk("t4_gnt_clr", int'(g), 8);
      chk("t4_vld", int'(out_vld), 1);
      chk("t4_out_det", int'(out_det), 0);
      chk("t4_det3", int'(det[3]), 0);
      cyc(4'b1111, 4'b0000, 4'b0000, g);
      chk("t4_ptr0", int'(g), 1);

      cyc(4'b0100, 4'b0000, 4'b0000, g);
      chk("t6_gnt2", int'(g), 4);
      for (int i = 0; i < 3; i++) begin
         cyc(4'b0000, 4'b0000, 4'b0000, g);
         chk("t6_idle_vld", int'(out_vld), 0);
         chk("t6_idle_ch", int'(out_ch), 2);
         chk("t6_idle_gnt", int'(g), 0);
      end
      cyc(4'b1111, 4'b0000, 4'b0000, g);
      chk("t6_gnt3", int'(g), 8);
      chk("t6_ch3", int'(out_ch), 3);

      reset_dut();
      cyc(4'b0001, 4'b0001, 4'b0000, g);
      cyc(4'b0001, 4'b0000, 4'b0000, g);
      chk("t5_pre_vld", int'(out_vld), 1);
      #1 rst = 1'b0;
      #1;
      chk("t5_async_vld", int'(out_vld), 0);
      chk("t5_async_gnt", int'(gnt), 0);
      chk("t5_async_det", int'(det), 0);
      chk("t5_async_out_det", int'(out_det), 0);
      @(negedge clk);
      #1 rst = 1'b1;
      cyc(4'b0001, 4'b0001, 4'b0000, g);
      chk("t5_after_det", int'(out_det), 0);
      chk("t5_after_vld", int'(out_vld), 1);
      cyc(4'b0001, 4'b0000, 4'b0000, g);
      cyc(4'b0001, 4'b0001, 4'b0000, g);
      chk("t5_redetect", int'(out_det), 1);

      req = '0; bit_in = '0; ctx_clr = '0;
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
